// File: rtl/lfsr_updown_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_updown_pkg
//  Description : Shared constants and helpers for the bidirectional LFSR
//                counter: default width/taps, the up-direction feedback mask
//                derivation and the default-width boundary states.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_updown_pkg;

    localparam int         DEFAULT_WIDTH = 8;
    localparam logic [7:0] DEFAULT_TAPS  = 8'hB1;

    // Widest register the mask helper supports.
    localparam int         MAX_WIDTH     = 32;

    // Last state before zero in each direction, for the default width.
    localparam logic [7:0] BOUNDARY_UP   = 8'h01;
    localparam logic [7:0] BOUNDARY_DOWN = 8'h80;

    // The up step must undo the down step. The bit shifted out on the down
    // step (old MSB) is recovered from the shifted-in feedback, so the up mask
    // is the down taps moved one place left with bit 0 always set.
    function automatic logic [MAX_WIDTH-1:0] up_mask(input logic [MAX_WIDTH-1:0] taps);
        return (taps << 1) | MAX_WIDTH'(1);
    endfunction

endpackage : lfsr_updown_pkg
`default_nettype wire

// File: rtl/lfsr_updown_next.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_updown_next
//  Description : Combinational next-state function of the bidirectional LFSR.
//                Down = shift left with XNOR feedback over TAPS;
//                Up   = shift right with XNOR feedback over the derived mask.
//                Optional macro LFSR_UPDOWN_LOCKUP_RECOVERY_EN maps the
//                all-ones lock-up state to zero.
//  Ports       : count      - current state
//                up_down    - 1 = up (shift right), 0 = down (shift left)
//                next_count - state after one step
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_updown_next
    import lfsr_updown_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_count
);

    localparam logic [MAX_WIDTH-1:0] c_umask_full = up_mask(MAX_WIDTH'(TAPS));
    localparam logic [WIDTH-1:0]     c_umask      = c_umask_full[WIDTH-1:0];

    logic             w_fb_down;
    logic             w_fb_up;
    logic [WIDTH-1:0] w_step;

    assign w_fb_down = ~^(count & TAPS);
    assign w_fb_up   = ~^(count & c_umask);

    assign w_step = up_down ? {w_fb_up, count[WIDTH-1:1]}
                            : {count[WIDTH-2:0], w_fb_down};

`ifdef LFSR_UPDOWN_LOCKUP_RECOVERY_EN
    // All-ones is a fixed point of XNOR feedback; escape it to zero.
    assign next_count = (&count) ? '0 : w_step;
`else
    assign next_count = w_step;
`endif

endmodule : lfsr_updown_next
`default_nettype wire

// File: rtl/lfsr_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_updown_counter
//  Description : Bidirectional maximal-length LFSR counter with a
//                combinational boundary flag for the selected direction.
//                Optional macro: LFSR_UPDOWN_LOCKUP_RECOVERY_EN (all-ones
//                state steps to zero instead of locking up).
//  Ports       : clk      - rising-edge clock
//                reset    - synchronous active-high reset (count <= 0)
//                enable   - advance one step this cycle
//                up_down  - 1 = up, 0 = down
//                count    - registered LFSR state
//                overflow - count is the last state before 0 in the
//                           current direction (pure decode)
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_updown_counter
    import lfsr_updown_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_boundary_up   = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_boundary_down = c_boundary_up << (WIDTH-1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    lfsr_updown_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .count      (r_count),
        .up_down    (up_down),
        .next_count (w_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_next;
        end
    end

    assign count    = r_count;
    assign overflow = up_down ? (r_count == c_boundary_up)
                              : (r_count == c_boundary_down);

endmodule : lfsr_updown_counter
`default_nettype wire

// File: tb/tb_lfsr_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_updown_counter
//  Description : Self-checking bench for lfsr_updown_counter: directed vector
//                table, randomized run against a sequence-position model,
//                full-cycle run with a hold, and lock-up state behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_updown_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic [7:0] count;
    logic       overflow;

    logic [7:0] lk_count;
    logic       lk_ud;
    logic [7:0] lk_next;

    int n_checks;
    int n_errors;

    lfsr_updown_counter #(
        .WIDTH (8),
        .TAPS  (8'hB1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .up_down  (up_down),
        .count    (count),
        .overflow (overflow)
    );

    // Separate next-state instance to exercise the unreachable all-ones state.
    lfsr_updown_next #(
        .WIDTH (8),
        .TAPS  (8'hB1)
    ) u_lockup (
        .count      (lk_count),
        .up_down    (lk_ud),
        .next_count (lk_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ud;
        logic [7:0] exp_count;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [23];

    // Model: the down sequence as a table; state is a position on the cycle.
    int seq [255];

    function automatic int down_rule(input int c);
        int p;
        p = 0;
        for (int b = 0; b < 8; b++)
            if (((c >> b) & 1) == 1 && ((8'hB1 >> b) & 1) == 1) p = p ^ 1;
        return ((c << 1) & 255) | (p ^ 1);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d);
        reset   = r;
        enable  = e;
        up_down = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic d,
                                input logic [7:0] c, input logic o);
        vec_t v;
        v.rst = r; v.en = e; v.ud = d; v.exp_count = c; v.exp_ov = o;
        return v;
    endfunction

    initial begin
        int pos;
        int zero_seen;
        logic r, e, d;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        up_down  = 1'b0;
        lk_count = 8'h00;
        lk_ud    = 1'b0;

        seq[0] = 0;
        for (int i = 1; i < 255; i++) seq[i] = down_rule(seq[i-1]);

        for (int i = 0; i < 5; i++) vecs[i] = mk(1, 1, 0, 8'h00, 0);
        vecs[5]  = mk(0, 1, 0, 8'h01, 0);
        vecs[6]  = mk(0, 1, 0, 8'h02, 0);
        vecs[7]  = mk(0, 1, 0, 8'h05, 0);
        vecs[8]  = mk(0, 1, 0, 8'h0A, 0);
        vecs[9]  = mk(0, 1, 0, 8'h15, 0);
        vecs[10] = mk(0, 1, 0, 8'h2B, 0);
        vecs[11] = mk(0, 1, 1, 8'h15, 0);
        vecs[12] = mk(0, 1, 1, 8'h0A, 0);
        vecs[13] = mk(0, 1, 1, 8'h05, 0);
        vecs[14] = mk(0, 1, 1, 8'h02, 0);
        vecs[15] = mk(0, 1, 1, 8'h01, 1);
        vecs[16] = mk(0, 1, 1, 8'h00, 0);
        vecs[17] = mk(0, 1, 1, 8'h80, 0);
        vecs[18] = mk(0, 0, 0, 8'h80, 1);
        vecs[19] = mk(0, 1, 1, 8'hC0, 0);
        vecs[20] = mk(0, 1, 1, 8'h60, 0);
        vecs[21] = mk(0, 0, 1, 8'h60, 0);
        vecs[22] = mk(1, 1, 1, 8'h00, 0);

        // Directed vectors.
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].ud);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            chk($sformatf("vec%0d_overflow", i), {7'd0, overflow}, {7'd0, vecs[i].exp_ov});
        end

        // Randomized run against the position model.
        step(1, 0, 0);
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = $urandom_range(0, 1);
            step(r, e, d);
            if (r)      pos = 0;
            else if (e) pos = d ? (pos + 254) % 255 : (pos + 1) % 255;
            chk("rand_count", count, 8'(seq[pos]));
            chk("rand_overflow", {7'd0, overflow},
                {7'd0, (d ? (pos == 1) : (pos == 254))});
        end

        // Full down cycle with a mid-run hold.
        step(1, 1, 0);
        zero_seen = 0;
        for (int i = 1; i <= 255; i++) begin
            step(0, 1, 0);
            if (i < 255) begin
                chk("cycle_count", count, 8'(seq[i]));
                if (count == 8'h00) zero_seen++;
            end
            if (i == 128) begin
                for (int h = 0; h < 10; h++) begin
                    step(0, 0, $urandom_range(0, 1));
                    chk("hold_count", count, 8'(seq[128]));
                end
            end
        end
        chk("cycle_early_zero", 8'(zero_seen), 8'd0);
        chk("cycle_wrap_zero", count, 8'h00);

        // Lock-up state.
        for (int k = 0; k < 2; k++) begin
            lk_count = 8'hFF;
            lk_ud    = k[0];
            #1;
`ifdef LFSR_UPDOWN_LOCKUP_RECOVERY_EN
            chk("lockup_next", lk_next, 8'h00);
`else
            chk("lockup_next", lk_next, 8'hFF);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lfsr_updown_counter
`default_nettype wire
